// File: rtl/preg_free_arbiter_if.sv
// Commit / squash-walker release groups and the free-list free port.
// The slave modport is the arbiter side; master is the requester/free-list side.
interface preg_free_arbiter_if #(
  parameter int PHY_REG_NUM = 64,
  parameter int CMT_WIDTH   = 4,
  parameter int WALK_WIDTH  = 4,
  parameter int FREE_WIDTH  = 4,
  parameter int BUF_DEPTH   = 16
);
  localparam int PW = $clog2(PHY_REG_NUM);
  localparam int CW = $clog2(BUF_DEPTH + 1);

  logic [CMT_WIDTH-1:0]           cmt_valid_i;
  logic [CMT_WIDTH-1:0][PW-1:0]   cmt_preg_i;
  logic                           cmt_ready_o;
  logic [WALK_WIDTH-1:0]          walk_valid_i;
  logic [WALK_WIDTH-1:0][PW-1:0]  walk_preg_i;
  logic                           walk_ready_o;
  logic [FREE_WIDTH-1:0]          free_valid_o;
  logic [FREE_WIDTH-1:0][PW-1:0]  free_preg_o;
  logic                           free_ready_i;
  logic                           empty_o;
  logic [CW-1:0]                  cnt_o;
  logic                           err_o;

  modport slave (
    input  cmt_valid_i, cmt_preg_i, walk_valid_i, walk_preg_i, free_ready_i,
    output cmt_ready_o, walk_ready_o, free_valid_o, free_preg_o, empty_o, cnt_o, err_o
  );

  modport master (
    output cmt_valid_i, cmt_preg_i, walk_valid_i, walk_preg_i, free_ready_i,
    input  cmt_ready_o, walk_ready_o, free_valid_o, free_preg_o, empty_o, cnt_o, err_o
  );
endinterface

// File: rtl/preg_free_arbiter.sv
// Arbitrates commit and squash-walker preg releases into a compacting FIFO feeding the
// free-list free port. Optional zero-preg check under `PREG_FREE_CHECK_EN (sticky err_o).
module preg_free_out_lane #(
  parameter int LANE = 0,
  parameter int PW   = 6,
  parameter int SW   = 6
) (
  input  logic [SW-1:0] avail_i,
  input  logic [PW-1:0] preg_i,
  output logic          valid_o,
  output logic [PW-1:0] preg_o
);
  assign valid_o = SW'(LANE) < avail_i;
  assign preg_o  = valid_o ? preg_i : '0;
endmodule

module preg_free_arbiter #(
  parameter int PHY_REG_NUM = 64,
  parameter int CMT_WIDTH   = 4,
  parameter int WALK_WIDTH  = 4,
  parameter int FREE_WIDTH  = 4,
  parameter int BUF_DEPTH   = 16
) (
  input  logic clk,
  input  logic rst,
  preg_free_arbiter_if.slave io
);
  localparam int PW = $clog2(PHY_REG_NUM);
  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int AW = $clog2(BUF_DEPTH);
  localparam int SW = $clog2(BUF_DEPTH + FREE_WIDTH + CMT_WIDTH + WALK_WIDTH + 1) + 1;

  logic [AW-1:0]                head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]                cnt_q, cnt_d;
  logic                         rr_q, rr_d;
  logic [BUF_DEPTH-1:0][PW-1:0] buf_q, buf_d;

  logic [SW-1:0] nc, nw, cnt_x, avail, pop, space, nc_acc, nw_acc, pushed;
  logic          req_c, req_w, fit_c, fit_w, fit_both, grant_c, grant_w;

  always_comb begin
    nc = '0;
    for (int i = 0; i < CMT_WIDTH; i++) nc = nc + SW'(io.cmt_valid_i[i]);
    nw = '0;
    for (int j = 0; j < WALK_WIDTH; j++) nw = nw + SW'(io.walk_valid_i[j]);
  end

  // Lanes drained this cycle free their slots for this cycle's pushes.
  assign cnt_x  = SW'(cnt_q);
  assign avail  = (cnt_x < SW'(FREE_WIDTH)) ? cnt_x : SW'(FREE_WIDTH);
  assign pop    = io.free_ready_i ? avail : '0;
  assign space  = SW'(BUF_DEPTH) - cnt_x + pop;

  assign req_c    = nc != '0;
  assign req_w    = nw != '0;
  assign fit_c    = nc <= space;
  assign fit_w    = nw <= space;
  assign fit_both = (nc + nw) <= space;

  // An empty group always fits, so its ready is high; rr only breaks true contention.
  always_comb begin
    grant_c = fit_c;
    grant_w = fit_w;
    if (fit_both) begin
      grant_c = 1'b1;
      grant_w = 1'b1;
    end else if (fit_c && fit_w) begin
      grant_c = ~rr_q;
      grant_w = rr_q;
    end
  end

  always_comb begin
    rr_d = rr_q;
    if (req_c && req_w && (grant_c ^ grant_w)) rr_d = grant_c;
  end

  assign nc_acc = grant_c ? nc : '0;
  assign nw_acc = grant_w ? nw : '0;
  assign pushed = nc_acc + nw_acc;

  // Commit lanes land first, walker lanes right behind them; indices wrap in AW bits.
  always_comb begin
    buf_d = buf_q;
    for (int i = 0; i < CMT_WIDTH; i++)
      if (grant_c && io.cmt_valid_i[i])
        buf_d[tail_q + AW'(i)] = io.cmt_preg_i[i];
    for (int j = 0; j < WALK_WIDTH; j++)
      if (grant_w && io.walk_valid_i[j])
        buf_d[tail_q + AW'(nc_acc) + AW'(j)] = io.walk_preg_i[j];
  end

  always_comb begin
    tail_d = tail_q + AW'(pushed);
    head_d = head_q + AW'(pop);
    cnt_d  = CW'(cnt_x + pushed - pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      rr_q   <= 1'b0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      rr_q   <= rr_d;
    end
  end

  always_ff @(posedge clk) buf_q <= buf_d;

  logic [FREE_WIDTH-1:0]          free_valid;
  logic [FREE_WIDTH-1:0][PW-1:0]  free_preg, rd_preg;

  for (genvar g = 0; g < FREE_WIDTH; g++) begin : g_out
    assign rd_preg[g] = buf_q[head_q + AW'(g)];
    preg_free_out_lane #(.LANE(g), .PW(PW), .SW(SW)) u_lane (
      .avail_i (avail),
      .preg_i  (rd_preg[g]),
      .valid_o (free_valid[g]),
      .preg_o  (free_preg[g])
    );
  end

  assign io.free_valid_o = free_valid;
  assign io.free_preg_o  = free_preg;
  assign io.cmt_ready_o  = grant_c;
  assign io.walk_ready_o = grant_w;
  assign io.empty_o      = cnt_q == '0;
  assign io.cnt_o        = cnt_q;

`ifdef PREG_FREE_CHECK_EN
  logic err_q, err_d, zero_hit;

  // Preg 0 is permanently mapped; releasing it means upstream bookkeeping is broken.
  always_comb begin
    zero_hit = 1'b0;
    for (int i = 0; i < CMT_WIDTH; i++)
      if (grant_c && io.cmt_valid_i[i] && io.cmt_preg_i[i] == '0) zero_hit = 1'b1;
    for (int j = 0; j < WALK_WIDTH; j++)
      if (grant_w && io.walk_valid_i[j] && io.walk_preg_i[j] == '0) zero_hit = 1'b1;
    err_d = err_q | zero_hit;
  end

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign io.err_o = err_q;
`else
  assign io.err_o = 1'b0;
`endif
endmodule

// File: tb/tb_preg_free_arbiter.sv
// Directed bench for preg_free_arbiter: ordering, dual grant, round-robin, full/pop
// interaction, FIFO wrap, mid-operation reset and the zero-preg flag.
module tb_preg_free_arbiter;
  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_err = 0;
  int   pushed, popped;

  always #5 clk = ~clk;

  preg_free_arbiter_if bus ();

  preg_free_arbiter u_dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    bus.cmt_valid_i  = '0;
    bus.walk_valid_i = '0;
  endtask

  task automatic set_cmt(input logic [3:0] v, input int p0, input int p1, input int p2, input int p3);
    bus.cmt_valid_i   = v;
    bus.cmt_preg_i[0] = 6'(p0);
    bus.cmt_preg_i[1] = 6'(p1);
    bus.cmt_preg_i[2] = 6'(p2);
    bus.cmt_preg_i[3] = 6'(p3);
  endtask

  task automatic set_walk(input logic [3:0] v, input int p0, input int p1, input int p2, input int p3);
    bus.walk_valid_i   = v;
    bus.walk_preg_i[0] = 6'(p0);
    bus.walk_preg_i[1] = 6'(p1);
    bus.walk_preg_i[2] = 6'(p2);
    bus.walk_preg_i[3] = 6'(p3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    bus.free_ready_i = 1'b0;
    set_cmt(4'b0000, 0, 0, 0, 0);
    set_walk(4'b0000, 0, 0, 0, 0);
    @(negedge clk);
    step();
    rst = 1'b0;

    // reset state
    chk("rst_cnt",   bus.cnt_o, 0);
    chk("rst_empty", bus.empty_o, 1);
    chk("rst_valid", bus.free_valid_o, 0);
    chk("rst_preg",  bus.free_preg_o, 0);
    chk("rst_err",   bus.err_o, 0);

    // basic ordering, no bypass
    set_cmt(4'b0011, 7, 9, 0, 0);
    bus.free_ready_i = 1'b1;
    #1;
    chk("basic_cmt_rdy",  bus.cmt_ready_o, 1);
    chk("basic_walk_rdy", bus.walk_ready_o, 1);
    chk("basic_nobypass", bus.free_valid_o, 0);
    step();
    idle();
    chk("basic_valid", bus.free_valid_o, 4'b0011);
    chk("basic_p0",    bus.free_preg_o[0], 7);
    chk("basic_p1",    bus.free_preg_o[1], 9);
    chk("basic_cnt",   bus.cnt_o, 2);
    step();
    chk("basic_empty", bus.empty_o, 1);

    // both sources fit together, commit first
    set_cmt(4'b0111, 1, 2, 3, 0);
    set_walk(4'b0011, 4, 5, 0, 0);
    #1;
    chk("both_cmt_rdy",  bus.cmt_ready_o, 1);
    chk("both_walk_rdy", bus.walk_ready_o, 1);
    step();
    idle();
    chk("both_valid0", bus.free_valid_o, 4'b1111);
    for (int i = 0; i < 4; i++) chk("both_lane", bus.free_preg_o[i], i + 1);
    chk("both_cnt", bus.cnt_o, 5);
    step();
    chk("both_valid1", bus.free_valid_o, 4'b0001);
    chk("both_tail",   bus.free_preg_o[0], 5);
    step();
    chk("both_empty", bus.empty_o, 1);

    // round-robin under contention, pops counted as space
    bus.free_ready_i = 1'b0;
    for (int r = 0; r < 3; r++) begin
      set_cmt(4'b1111, 10 + 4*r, 11 + 4*r, 12 + 4*r, 13 + 4*r);
      step();
    end
    idle();
    chk("rr_fill_cnt", bus.cnt_o, 12);
    set_cmt(4'b1111, 30, 31, 32, 33);
    set_walk(4'b1111, 40, 41, 42, 43);
    for (int r = 0; r < 4; r++) begin
      bus.free_ready_i = (r != 0);
      #1;
      chk("rr_cmt_rdy",  bus.cmt_ready_o, (r % 2) == 0);
      chk("rr_walk_rdy", bus.walk_ready_o, (r % 2) == 1);
      step();
      chk("rr_cnt", bus.cnt_o, 16);
    end
    bus.free_ready_i = 1'b0;
    #1;
    chk("full_cmt_rdy",  bus.cmt_ready_o, 0);
    chk("full_walk_rdy", bus.walk_ready_o, 0);
    bus.cmt_valid_i = '0;
    #1;
    chk("full_nocmt_rdy", bus.cmt_ready_o, 1);
    chk("full_walk_rdy2", bus.walk_ready_o, 0);
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;

    // reset mid-operation discards in-flight entries
    set_cmt(4'b1111, 1, 2, 3, 4);
    step();
    set_cmt(4'b0111, 5, 6, 7, 0);
    step();
    idle();
    chk("mid_cnt7", bus.cnt_o, 7);
    set_cmt(4'b1111, 8, 9, 10, 11);
    bus.free_ready_i = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle();
    bus.free_ready_i = 1'b0;
    chk("mid_cnt",   bus.cnt_o, 0);
    chk("mid_empty", bus.empty_o, 1);
    chk("mid_valid", bus.free_valid_o, 0);
    chk("mid_preg",  bus.free_preg_o, 0);

    // 20 pregs through the 16-entry buffer, crossing the wrap point
    pushed = 0;
    popped = 0;
    for (int k = 0; k < 60 && popped < 20; k++) begin
      if (pushed < 20) set_cmt(4'b1111, 21 + pushed, 22 + pushed, 23 + pushed, 24 + pushed);
      else idle();
      bus.free_ready_i = (k >= 3);
      #1;
      if (bus.free_ready_i)
        for (int i = 0; i < 4; i++)
          if (bus.free_valid_o[i]) begin
            chk("wrap_seq", bus.free_preg_o[i], 21 + popped);
            popped++;
          end
      if (pushed < 20 && bus.cmt_ready_o) pushed += 4;
      step();
    end
    idle();
    bus.free_ready_i = 1'b0;
    chk("wrap_popped", popped, 20);
    chk("wrap_empty",  bus.empty_o, 1);

    // zero preg release
    set_cmt(4'b0001, 0, 0, 0, 0);
    step();
    idle();
    chk("zero_cnt", bus.cnt_o, 1);
`ifdef PREG_FREE_CHECK_EN
    chk("zero_err", bus.err_o, 1);
    step();
    step();
    chk("zero_err_sticky", bus.err_o, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("zero_err_clr", bus.err_o, 0);
`else
    chk("zero_err_off", bus.err_o, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
